// File: rtl/sys_reset_seq.sv
// sys_reset_seq: PLL reset pulse, lock qualification and staggered per-domain reset release.
// Optional feature: define PLL_AUTO_RESTART_EN to restart the PLL after LOCK_TIMEOUT cycles without lock.
module sys_reset_seq #(
    parameter int NUM_CHANNELS   = 3,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pll_locked,
    input  logic                    sw_reset,
    output logic                    pll_rst,
    output logic [NUM_CHANNELS-1:0] chan_reset,
    output logic                    all_ready,
    output logic                    lock_lost,
    output logic [7:0]              restart_count
);
    localparam int REL_SPAN = STAGGER_CYCLES * NUM_CHANNELS;
    localparam int MAX_AB   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CD   = (REL_SPAN > LOCK_TIMEOUT) ? REL_SPAN : LOCK_TIMEOUT;
    localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PLL_RST_END = CNT_W'(PLL_RST_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_END = CNT_W'((NUM_CHANNELS - 1) * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nx;
    logic [NUM_CHANNELS-1:0] chan_nx;
    logic                    lost_nx;
    logic                    lock_meta_p0;
    logic                    locked_s;

`ifdef PLL_AUTO_RESTART_EN
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
    logic restart_inc;
`endif

    // Stage p0 -> locked_s: two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_p0 <= 1'b0;
            locked_s     <= 1'b0;
        end else begin
            lock_meta_p0 <= pll_locked;
            locked_s     <= lock_meta_p0;
        end
    end

    // cnt holds elapsed cycles in PLL_RESET, so a fresh entry preloads 1 while reset leaves it at 0
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chan_nx  = '1;
        lost_nx  = 1'b0;
`ifdef PLL_AUTO_RESTART_EN
        restart_inc = 1'b0;
`endif
        case (state)
            PLL_RESET: begin
                if (cnt == PLL_RST_END) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end
`ifdef PLL_AUTO_RESTART_EN
                else if (cnt == TIMEOUT_END) begin
                    state_nx    = PLL_RESET;
                    cnt_nx      = CNT_ONE;
                    restart_inc = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
`endif
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_END) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        chan_nx[k] = (cnt < CNT_W'(k * STAGGER_CYCLES));
                    end
                    if (cnt == RELEASE_END) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                    lost_nx  = 1'b1;
                end else begin
                    chan_nx = '0;
                end
            end
            default: begin
                state_nx = PLL_RESET;
                cnt_nx   = '0;
            end
        endcase

        // Software request wins over everything, including a simultaneous lock loss
        if (sw_reset) begin
            state_nx = PLL_RESET;
            cnt_nx   = CNT_ONE;
            chan_nx  = '1;
            lost_nx  = 1'b0;
`ifdef PLL_AUTO_RESTART_EN
            restart_inc = 1'b0;
`endif
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLL_RESET;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            chan_reset <= '1;
            all_ready  <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pll_rst    <= (state_nx == PLL_RESET);
            chan_reset <= chan_nx;
            all_ready  <= (state_nx == RUN);
            lock_lost  <= lost_nx;
        end
    end

`ifdef PLL_AUTO_RESTART_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            restart_count <= 8'd0;
        end else if (restart_inc && (restart_count != 8'hFF)) begin
            restart_count <= restart_count + 8'd1;
        end
    end
`else
    assign restart_count = 8'd0;
`endif

endmodule

// File: tb/tb_sys_reset_seq.sv
// tb_sys_reset_seq: directed and randomized checks of sys_reset_seq against a phase/elapsed-time model.
// Builds with or without PLL_AUTO_RESTART_EN.
`timescale 1ns/1ps
module tb_sys_reset_seq;
    localparam int NCH = 3;
    localparam int PRC = 4;
    localparam int STC = 8;
    localparam int SGC = 2;
    localparam int LTO = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pll_locked = 1'b0;
    logic           sw_reset = 1'b0;
    logic           pll_rst;
    logic [NCH-1:0] chan_reset;
    logic           all_ready;
    logic           lock_lost;
    logic [7:0]     restart_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    sys_reset_seq #(
        .NUM_CHANNELS  (NCH),
        .PLL_RST_CYCLES(PRC),
        .STABLE_CYCLES (STC),
        .STAGGER_CYCLES(SGC),
        .LOCK_TIMEOUT  (LTO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .sw_reset     (sw_reset),
        .pll_rst      (pll_rst),
        .chan_reset   (chan_reset),
        .all_ready    (all_ready),
        .lock_lost    (lock_lost),
        .restart_count(restart_count)
    );

    always #5 clk = ~clk;

    // Reference: current phase plus cycles elapsed in it; lock seen through a 2-cycle delay line
    typedef enum {M_PLLRST, M_WAIT, M_STABLE, M_REL, M_RUN} phase_t;
    phase_t ph = M_PLLRST;
    int     el = -1;
    int     restarts = 0;
    bit     m_lost = 1'b0;
    bit     dly [2];

    task automatic model_step(input bit r, input bit sw, input bit lk_in);
        bit lk;
        lk = dly[1];
        m_lost = 1'b0;
        if (r) begin
            ph = M_PLLRST;
            el = -1;
            restarts = 0;
            dly[0] = 1'b0;
            dly[1] = 1'b0;
            return;
        end
        dly[1] = dly[0];
        dly[0] = lk_in;
        if (sw) begin
            ph = M_PLLRST;
            el = 0;
        end else begin
            case (ph)
                M_PLLRST: begin
                    el++;
                    if (el == PRC) begin ph = M_WAIT; el = 0; end
                end
                M_WAIT: begin
                    if (lk) begin
                        ph = M_STABLE;
                        el = 0;
                    end else begin
                        el++;
`ifdef PLL_AUTO_RESTART_EN
                        if (el == LTO) begin
                            ph = M_PLLRST;
                            el = 0;
                            if (restarts < 255) restarts++;
                        end
`endif
                    end
                end
                M_STABLE: begin
                    if (!lk) begin
                        ph = M_WAIT; el = 0;
                    end else begin
                        el++;
                        if (el == STC) begin ph = M_REL; el = 0; end
                    end
                end
                M_REL: begin
                    if (!lk) begin
                        ph = M_WAIT; el = 0;
                    end else begin
                        el++;
                        if (el == 1 + (NCH - 1) * SGC) begin ph = M_RUN; el = 0; end
                    end
                end
                M_RUN: begin
                    if (!lk) begin ph = M_WAIT; el = 0; m_lost = 1'b1; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit sw, input bit lk);
        logic [NCH-1:0] ec;
        reset = r;
        sw_reset = sw;
        pll_locked = lk;
        @(posedge clk);
        model_step(r, sw, lk);
        if (r) cyc = -1; else cyc++;
        #1;
        for (int k = 0; k < NCH; k++) begin
            ec[k] = (ph == M_RUN) ? 1'b0 : (ph == M_REL) ? (el < 1 + k * SGC) : 1'b1;
        end
        chk("m_pll_rst", pll_rst, (ph == M_PLLRST));
        chk("m_chan", chan_reset, ec);
        chk("m_ready", all_ready, (ph == M_RUN));
        chk("m_lost", lock_lost, m_lost);
        chk("m_rcount", restart_count, restarts);
    endtask

    initial begin
        int  run_left;
        bit  lvl;

        dly[0] = 1'b0;
        dly[1] = 1'b0;

        // Reset values
        repeat (3) step(1'b1, 1'b0, 1'b1);
        chk("rst_pll", pll_rst, 1);
        chk("rst_chan", chan_reset, 3'b111);
        chk("rst_ready", all_ready, 0);
        chk("rst_lost", lock_lost, 0);
        chk("rst_rcount", restart_count, 0);

        // Bring-up with lock held high
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (cyc == 3)  chk("up_pll3", pll_rst, 1);
            if (cyc == 4)  chk("up_pll4", pll_rst, 0);
            if (cyc == 13) chk("up_chan13", chan_reset, 3'b111);
            if (cyc == 14) chk("up_chan14", chan_reset, 3'b110);
            if (cyc == 15) chk("up_chan15", chan_reset, 3'b110);
            if (cyc == 16) chk("up_chan16", chan_reset, 3'b100);
            if (cyc == 17) chk("up_ready17", all_ready, 0);
            if (cyc == 18) begin
                chk("up_chan18", chan_reset, 3'b000);
                chk("up_ready18", all_ready, 1);
            end
        end

        // One-cycle lock drop in RUN
        repeat (5) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("drop_ready_hold", all_ready, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("drop_chan", chan_reset, 3'b111);
        chk("drop_ready", all_ready, 0);
        chk("drop_lost", lock_lost, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("drop_lost_once", lock_lost, 0);
        repeat (12) step(1'b0, 1'b0, 1'b1);
        chk("relock_ready_early", all_ready, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("relock_ready", all_ready, 1);

        // Lock toggling with a 6-cycle period never qualifies
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, (i % 6) >= 3);
            if (i >= 3) chk("tog_chan", chan_reset, 3'b111);
        end

        // sw_reset coinciding with lock loss in RUN
        repeat (24) step(1'b0, 1'b0, 1'b1);
        chk("sw_pre_ready", all_ready, 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("sw_pll", pll_rst, 1);
        chk("sw_lost", lock_lost, 0);
        chk("sw_chan", chan_reset, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("sw_pll_hold", pll_rst, 1);
            chk("sw_lost_hold", lock_lost, 0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("sw_pll_end", pll_rst, 0);

        // reset during RELEASE after the first channel released
        step(1'b1, 1'b0, 1'b1);
        while (cyc < 15) step(1'b0, 1'b0, 1'b1);
        chk("midrel_chan", chan_reset, 3'b110);
        step(1'b1, 1'b0, 1'b1);
        chk("abort_chan", chan_reset, 3'b111);
        chk("abort_pll", pll_rst, 1);
        chk("abort_ready", all_ready, 0);

        // Randomized lock runs with occasional sw_reset and reset
        run_left = 0;
        lvl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                lvl = ($urandom_range(0, 3) != 0);
                run_left = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
            end
            run_left--;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 149) == 0), lvl);
        end

        // Lock never arrives
        step(1'b1, 1'b0, 1'b0);
`ifdef PLL_AUTO_RESTART_EN
        for (int i = 0; i < (PRC + LTO) * 258; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cyc == 35) chk("ar_pll35", pll_rst, 0);
            if (cyc == 36) begin
                chk("ar_pll36", pll_rst, 1);
                chk("ar_rcount36", restart_count, 1);
            end
            if (cyc == 39) chk("ar_pll39", pll_rst, 1);
            if (cyc == 40) chk("ar_pll40", pll_rst, 0);
            if (cyc == 72) chk("ar_rcount72", restart_count, 2);
        end
        chk("ar_saturate", restart_count, 255);
`else
        for (int i = 0; i < LTO * 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cyc >= PRC) chk("nr_pll", pll_rst, 0);
        end
        chk("nr_rcount", restart_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_reset_seq.md
SYS_RESET_SEQ -- requirements
Module: sys_reset_seq

Interface
REQ-001 Parameter NUM_CHANNELS, default 3: number of sequenced reset outputs, range 1-16.
REQ-002 Parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before any release.
REQ-004 Parameter STAGGER_CYCLES, default 16: spacing between successive channel releases, minimum 1.
REQ-005 Parameter LOCK_TIMEOUT, default 65536: maximum cycles spent waiting for lock before a PLL restart (REQ-025).
REQ-006 clk  input  1  free-running reference clock, independent of the PLL outputs.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pll_locked  input  1  asynchronous PLL lock indication.
REQ-009 sw_reset  input  1  single-cycle request to resequence from a PLL reset.
REQ-010 pll_rst  output  1  reset to the PLL, active high.
REQ-011 chan_reset  output  NUM_CHANNELS  per-domain resets, active high, bit 0 released first.
REQ-012 all_ready  output  1  high only when every chan_reset bit is low.
REQ-013 lock_lost  output  1  one-cycle pulse on each loss of lock after lock was first achieved.
REQ-014 restart_count  output  8  saturating count of timeout-triggered PLL restarts.

Function
REQ-015 pll_locked shall pass through a two-flop synchroniser (locked_s), with 2 cycles of latency; both flops clear on reset.
REQ-016 The FSM shall have the states PLL_RESET, WAIT_LOCK, STABLE, RELEASE and RUN; all outputs are registered.
REQ-017 PLL_RESET: pll_rst=1 and all chan_reset=1; exit to WAIT_LOCK after exactly PLL_RST_CYCLES cycles.
REQ-018 WAIT_LOCK: pll_rst=0 and all chan_reset=1; when locked_s=1, go to STABLE with the stability counter cleared.
REQ-019 STABLE: locked_s=0 returns the FSM to WAIT_LOCK; after STABLE_CYCLES consecutive locked cycles, go to RELEASE.
REQ-020 RELEASE: with T the first cycle in RELEASE, chan_reset[k] deasserts at cycle T+1+k*STAGGER_CYCLES; the FSM enters RUN in the cycle chan_reset[NUM_CHANNELS-1] deasserts, and all_ready rises in that same cycle.
REQ-021 Lock loss in RELEASE or RUN: all chan_reset and all_ready shall switch to their reset state on the next edge, and the FSM goes to WAIT_LOCK; lock_lost pulses for 1 cycle only when the loss occurs in RUN.
REQ-022 sw_reset shall go to PLL_RESET from any state, taking priority over lock loss in the same cycle; lock_lost is not pulsed.
REQ-023 NUM_CHANNELS=1: chan_reset[0] and all_ready change together at T+1.
REQ-024 Counters shall be sized to the maximum of PLL_RST_CYCLES, STABLE_CYCLES, STAGGER_CYCLES*NUM_CHANNELS and LOCK_TIMEOUT; no wrap shall occur within a state.

Configuration
REQ-025 With PLL_AUTO_RESTART_EN defined: if WAIT_LOCK lasts LOCK_TIMEOUT cycles, go to PLL_RESET and increment restart_count, saturating at 255; the timeout counter clears on each entry to WAIT_LOCK.
REQ-026 Without PLL_AUTO_RESTART_EN: WAIT_LOCK waits indefinitely, no timeout logic is built, and restart_count is tied to 0.

Reset
REQ-027 While reset=1: state=PLL_RESET, pll_rst=1, chan_reset=all ones, all_ready=0, lock_lost=0, restart_count=0, all counters=0.
REQ-028 Asserting reset mid-sequence shall abort immediately; the next edge yields the REQ-027 values regardless of state.

Verification (bench parameters: NUM_CHANNELS=3, PLL_RST_CYCLES=4, STABLE_CYCLES=8, STAGGER_CYCLES=2, LOCK_TIMEOUT=32; cycle 0 = first edge with reset=0)
REQ-029 pll_locked held at 1 -> pll_rst high for cycles 0-3; chan_reset[0] low at 14, [1] at 16, [2] at 18; all_ready high at 18.
REQ-030 Bring up as in REQ-029, then drop pll_locked for 1 cycle in RUN -> 3 cycles later chan_reset=111, all_ready=0, lock_lost pulses once; the release sequence repeats after lock returns.
REQ-031 pll_locked toggling with a period of 6 cycles -> the FSM never leaves STABLE/WAIT_LOCK and chan_reset stays 111.
REQ-032 PLL_AUTO_RESTART_EN defined, pll_locked=0 -> pll_rst repulses every 4+32 cycles, restart_count increments each time and saturates at 255.
REQ-033 sw_reset and lock loss in the same RUN cycle -> PLL_RESET entered, pll_rst high for 4 cycles, lock_lost stays 0.
REQ-034 reset asserted during RELEASE after chan_reset[0] has released -> next edge: chan_reset=111, pll_rst=1, all_ready=0.
